man_squeeze_ctrl: RTL and testbench
===================================

// Module: man_squeeze_ctrl
// PURPOSE
//  Next-generation squeeze/charge controller for the jumping man.
//  - Grows a squeeze counter while the game FSM is in the charge (ACCU) state.
//  - On release, latches the final charge for the jump-distance logic.
//  - Then unwinds the squeeze at a configurable rate as a rebound animation.
//  - Sits between the game state machine and the man-sprite renderer and jump calculator.
//  - Runs on one clock; timing comes from a tick-enable prescaler, with no derived clocks.
// PARAMETERS
//  STATE_W   3        width of the game state code input
//  ACCU_CODE 3'd3     state code meaning "charging"
//  TICK_DIV  1048576  clk_machine cycles per squeeze tick (>=2)
//  CNT_W     4        squeeze counter width
//  MAX_CNT   15       saturation value of the counter (<= 2**CNT_W-1, >=1)
//  OUT_W     3        sprite level width (<= CNT_W); level = cnt[CNT_W-1 -: OUT_W]
//  REL_STEP  2        counter decrement per tick during release (>=1)
// PORTS
//  clk_machine      in   1        system clock (25 MHz)
//  rst_machine      in   1        asynchronous reset, active-low
//  i_state          in   STATE_W  current game state code
//  i_clear          in   1        synchronous clear (game restart), active-high
//  o_squeeze_level  out  OUT_W    sprite compression level
//  o_charge         out  CNT_W    charge latched at release
//  o_charge_valid   out  1        one-cycle pulse when o_charge updates
//  o_full           out  1        1 while the counter is saturated in FULL
// BEHAVIOUR
//  Reset and clear
//  - rst_machine low (async): FSM=IDLE, cnt=0, presc=0, o_charge=0, o_charge_valid=0, o_full=0.
//  - i_clear=1 (sync): same values as reset. It has priority over all else, and no valid pulse is issued.
//  Prescaler and tick
//  - presc counts 0..TICK_DIV-1 and wraps; tick=1 in the cycle where presc==TICK_DIV-1.
//  - presc is cleared to 0 on every edge that enters CHARGE or RELEASE.
//  - Therefore the first tick after entry occurs TICK_DIV cycles after the entry edge.
//  Charge decode
//  - accu = (i_state==ACCU_CODE), sampled each edge.
//  FSM states and transitions
//  - IDLE: cnt=0. If accu=1, go to CHARGE.
//  - CHARGE:
//    - if accu=0: o_charge<=cnt (value before any same-cycle tick), o_charge_valid<=1, go to RELEASE;
//    - else on tick: cnt<=cnt+1, and if cnt+1==MAX_CNT go to FULL.
//  - FULL: cnt holds at MAX_CNT; o_full=1. If accu=0: o_charge<=MAX_CNT, pulse valid, go to RELEASE.
//  - RELEASE:
//    - if accu=1: go to CHARGE and continue from the current cnt, with no valid pulse;
//    - else on tick: cnt <= (cnt>REL_STEP) ? cnt-REL_STEP : 0;
//    - when cnt==0 (and no tick pending), go to IDLE.
//  Arithmetic
//  - The counter never wraps: it saturates at MAX_CNT and floors at 0.
//  Outputs
//  - All outputs are registered.
//  - o_squeeze_level follows cnt with no extra latency.
//  - o_charge holds its value until the next release.
//  Simultaneous events
//  - Release beats tick.
//  - i_clear beats release, so there is no pulse.
// TESTING (TICK_DIV=4, defaults otherwise)
//  1. Hold rst_machine=0 with i_state=3 -> all outputs 0; release reset -> CHARGE on the next edge.
//  2. Hold i_state=3 -> cnt +1 every 4 cycles; after 15 ticks o_full=1, level=7, and cnt stays 15.
//  3. Set i_state=0 at cnt=6 -> next edge o_charge=6 with a 1-cycle valid pulse; cnt goes 4,2,0 every 4 cycles, then IDLE.
//  4. Re-assert i_state=3 in RELEASE at cnt=4 -> cnt goes 5,6,... with no o_charge_valid.
//  5. Drop accu in the tick cycle at cnt=9 -> o_charge=9, not 10.
//  6. Assert i_clear mid-CHARGE -> cnt=0, IDLE, no pulse; assert async reset mid-RELEASE -> outputs 0 immediately.

Source files
------------

// File: rtl/man_squeeze_ctrl.sv
// Squeeze/charge controller for the jumping man: grows a squeeze counter while
// charging, latches the charge on release, then unwinds it as a rebound.
module man_squeeze_ctrl #(
  parameter int unsigned            STATE_W   = 3,
  parameter logic [STATE_W-1:0]     ACCU_CODE = STATE_W'(3),
  parameter int unsigned            TICK_DIV  = 1048576,
  parameter int unsigned            CNT_W     = 4,
  parameter int unsigned            MAX_CNT   = 15,
  parameter int unsigned            OUT_W     = 3,
  parameter int unsigned            REL_STEP  = 2
) (
  input  logic               clk_machine,
  input  logic               rst_machine,
  input  logic [STATE_W-1:0] i_state,
  input  logic               i_clear,
  output logic [OUT_W-1:0]   o_squeeze_level,
  output logic [CNT_W-1:0]   o_charge,
  output logic               o_charge_valid,
  output logic               o_full
);

  localparam int unsigned       PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0]  CNT_STEP   = CNT_W'(REL_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHARGE,
    S_FULL,
    S_RELEASE
  } state_e;

  state_e             state_q;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   charge_q;
  logic               valid_q;
  logic               full_q;

  logic accu;
  logic tick;

  assign accu    = (i_state == ACCU_CODE);
  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch reads the pre-edge values (e.g. o_charge latches cnt before a same-cycle tick).
  always_ff @(posedge clk_machine or negedge rst_machine) begin
    if (!rst_machine) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      charge_q <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else if (i_clear) begin
      // Restart wins over everything, including a pending release pulse.
      state_q  <= S_IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      charge_q <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      presc_q <= presc_d;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (accu) begin
            state_q <= S_CHARGE;
            presc_q <= '0;
          end
        end

        S_CHARGE: begin
          if (!accu) begin
            charge_q <= cnt_q;
            valid_q  <= 1'b1;
            state_q  <= S_RELEASE;
            presc_q  <= '0;
          end else if (tick) begin
            // Saturate rather than wrap, even if re-entered already at the top.
            if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
              cnt_q   <= CNT_MAX;
              state_q <= S_FULL;
              full_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        S_FULL: begin
          cnt_q  <= CNT_MAX;
          full_q <= accu;
          if (!accu) begin
            charge_q <= CNT_MAX;
            valid_q  <= 1'b1;
            state_q  <= S_RELEASE;
            presc_q  <= '0;
          end
        end

        S_RELEASE: begin
          if (accu) begin
            state_q <= S_CHARGE;
            presc_q <= '0;
          end else if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            cnt_q <= (cnt_q > CNT_STEP) ? cnt_q - CNT_STEP : '0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_squeeze_level = cnt_q[CNT_W-1 -: OUT_W];
  assign o_charge        = charge_q;
  assign o_charge_valid  = valid_q;
  assign o_full          = full_q;

endmodule

// File: tb/tb_man_squeeze_ctrl.sv
// Bench for man_squeeze_ctrl: directed scenarios plus random stimulus, all
// checked against a cycle-level behavioural model of the squeeze rules.
module tb_man_squeeze_ctrl;

  localparam int TD   = 4;
  localparam int MAXC = 15;
  localparam int REL  = 2;
  localparam int CW   = 4;
  localparam int OW   = 3;

  logic          clk_machine = 1'b0;
  logic          rst_machine;
  logic [2:0]    i_state;
  logic          i_clear;
  logic [OW-1:0] o_squeeze_level;
  logic [CW-1:0] o_charge;
  logic          o_charge_valid;
  logic          o_full;

  man_squeeze_ctrl #(
    .STATE_W  (3),
    .ACCU_CODE(3'd3),
    .TICK_DIV (TD),
    .CNT_W    (CW),
    .MAX_CNT  (MAXC),
    .OUT_W    (OW),
    .REL_STEP (REL)
  ) dut (
    .clk_machine    (clk_machine),
    .rst_machine    (rst_machine),
    .i_state        (i_state),
    .i_clear        (i_clear),
    .o_squeeze_level(o_squeeze_level),
    .o_charge       (o_charge),
    .o_charge_valid (o_charge_valid),
    .o_full         (o_full)
  );

  always #5 clk_machine = ~clk_machine;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: cycles since last entry give the tick phase; "active"
  // means a squeeze is in progress, "charging" distinguishes growth from unwind.
  int m_cnt, m_charge, m_phase;
  bit m_active, m_charging, m_full, m_valid;

  function automatic void m_reset();
    m_cnt = 0; m_charge = 0; m_phase = 0;
    m_active = 0; m_charging = 0; m_full = 0; m_valid = 0;
  endfunction

  function automatic void m_step(input bit clr, input bit accu);
    bit tick;
    tick    = (m_phase % TD) == TD - 1;
    m_valid = 0;
    m_phase++;
    if (clr) begin
      m_reset();
    end else if (!m_active) begin
      m_cnt = 0;
      if (accu) begin m_active = 1; m_charging = 1; m_phase = 0; end
    end else if (m_charging) begin
      if (!accu) begin
        m_charge = m_cnt; m_valid = 1; m_charging = 0; m_full = 0; m_phase = 0;
      end else if (tick && !m_full) begin
        m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
        if (m_cnt == MAXC) m_full = 1;
      end
    end else begin
      if (accu) begin m_charging = 1; m_phase = 0; end
      else if (m_cnt == 0) m_active = 0;
      else if (tick) m_cnt = (m_cnt > REL) ? m_cnt - REL : 0;
    end
  endfunction

  task automatic compare_all();
    check("level", int'(o_squeeze_level), m_cnt >> (CW - OW));
    check("charge", int'(o_charge), m_charge);
    check("valid", int'(o_charge_valid), int'(m_valid));
    check("full", int'(o_full), int'(m_full));
  endtask

  task automatic cycle(input bit clr, input logic [2:0] st);
    i_clear = clr;
    i_state = st;
    @(posedge clk_machine);
    m_step(clr, st == 3'd3);
    @(negedge clk_machine);
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, int'(o_squeeze_level), 0);
    check({tag, "_charge"}, int'(o_charge), 0);
    check({tag, "_valid"}, int'(o_charge_valid), 0);
    check({tag, "_full"}, int'(o_full), 0);
  endtask

  initial begin
    int guard;
    logic [2:0] st;
    int hold;
    int i;

    // 1. reset held with charging code present
    rst_machine = 1'b0;
    i_state     = 3'd3;
    i_clear     = 1'b0;
    m_reset();
    #2;
    check_zero("rst");
    repeat (3) @(negedge clk_machine);
    check_zero("rst_hold");
    rst_machine = 1'b1;
    cycle(0, 3'd3);
    check("enter_level", int'(o_squeeze_level), 0);

    // 2. charge to saturation and hold
    guard = 0;
    while (!m_full && guard < 200) begin cycle(0, 3'd3); guard++; end
    if (guard >= 200) check("timeout_full", 0, 1);
    check("full_flag", int'(o_full), 1);
    check("full_level", int'(o_squeeze_level), 7);
    repeat (10) cycle(0, 3'd3);
    check("full_hold", int'(o_squeeze_level), 7);

    // 3. release at cnt=6
    cycle(1, 3'd0);
    guard = 0;
    while (m_cnt != 6 && guard < 200) begin cycle(0, 3'd3); guard++; end
    if (guard >= 200) check("timeout_cnt6", 0, 1);
    cycle(0, 3'd0);
    check("rel6_charge", int'(o_charge), 6);
    check("rel6_valid", int'(o_charge_valid), 1);
    cycle(0, 3'd0);
    check("rel6_pulse_end", int'(o_charge_valid), 0);

    // 4. re-charge from release at cnt=4, no pulse
    guard = 0;
    while (m_cnt != 4 && guard < 50) begin cycle(0, 3'd0); guard++; end
    if (guard >= 50) check("timeout_cnt4", 0, 1);
    cycle(0, 3'd3);
    check("recharge_valid", int'(o_charge_valid), 0);
    guard = 0;
    while (m_cnt != 6 && guard < 50) begin
      cycle(0, 3'd3);
      check("recharge_nopulse", int'(o_charge_valid), 0);
      guard++;
    end
    if (guard >= 50) check("timeout_recharge", 0, 1);
    check("recharge_level", int'(o_squeeze_level), 3);

    // 5. release coinciding with a tick at cnt=9
    guard = 0;
    while (!(m_cnt == 9 && (m_phase % TD) == TD - 1) && guard < 200) begin
      cycle(0, 3'd3); guard++;
    end
    if (guard >= 200) check("timeout_cnt9", 0, 1);
    cycle(0, 3'd5);
    check("tick_rel_charge", int'(o_charge), 9);
    guard = 0;
    while (m_active && guard < 100) begin cycle(0, 3'd1); guard++; end
    if (guard >= 100) check("timeout_idle", 0, 1);
    check("idle_level", int'(o_squeeze_level), 0);

    // 6. sync clear mid-charge, async reset mid-release
    repeat (9) cycle(0, 3'd3);
    cycle(1, 3'd3);
    check("clear_level", int'(o_squeeze_level), 0);
    check("clear_valid", int'(o_charge_valid), 0);
    repeat (14) cycle(0, 3'd3);
    cycle(0, 3'd0);
    cycle(0, 3'd0);
    #2 rst_machine = 1'b0;
    #1 check_zero("async");
    m_reset();
    @(negedge clk_machine);
    rst_machine = 1'b1;

    // random run-length stimulus
    i = 0;
    while (i < 3000) begin
      st   = ($urandom_range(0, 9) < 6) ? 3'd3 : 3'($urandom_range(0, 7));
      hold = int'($urandom_range(1, 40));
      for (int k = 0; k < hold && i < 3000; k++) begin
        cycle($urandom_range(0, 199) == 0, st);
        i++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
